// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, PC register index, requester encoding, one-hot decode.
// Latency: none (package only).
// Backpressure: n/a.
package rf_pkg;

  localparam int RF_AW = 4;
  localparam int RF_DW = 32;

  localparam logic [RF_AW-1:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ALU  = 2'd1,
    REQ_MEM  = 2'd2
  } req_e;

  // Register index to one-hot select, also used by the register file write decoder.
  function automatic logic [(1<<RF_AW)-1:0] rf_onehot(input logic [RF_AW-1:0] idx);
    logic [(1<<RF_AW)-1:0] one;
    one = '0;
    one[idx] = 1'b1;
    return one;
  endfunction

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating starvation counter: clear wins over hold, hold wins over increment; at_max flags saturation.
// Latency: count updates one cycle after the controlling inputs; at_max is combinational from the count.
// Backpressure: none; hold simply freezes the count.
module wb_starve_counter #(
  parameter int MAX = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic hold,
  input  logic inc,
  output logic at_max
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear, else freeze, else saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (!hold && inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU and load write-back; load has priority, ALU starvation-guarded.
// Latency: a request accepted at edge N drives RFLd/C/PW from edge N to edge N+1 (one registered cycle).
// Backpressure: ready is combinational from valids, hold and starvation state; hold or reset blocks all grants.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_dest,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          hold,
  output logic [AW-1:0] C,
  output logic [DW-1:0] PW,
  output logic          RFLd,
  output logic          PCLd,
  output logic [15:0]   pend_mask
);

  req_e grant;
  logic starve_at_max;

  logic [AW-1:0] c_q,    c_d;
  logic [DW-1:0] pw_q,   pw_d;
  logic          rfld_q, rfld_d;
  logic          pcld_q, pcld_d;

  // Grant selection: load wins contention unless the ALU has been denied STARVE_MAX times in a row.
  always_comb begin
    grant = REQ_NONE;
    if (RST && !hold) begin
      if (alu_valid && mem_valid) begin
        grant = starve_at_max ? REQ_ALU : REQ_MEM;
      end else if (alu_valid) begin
        grant = REQ_ALU;
      end else if (mem_valid) begin
        grant = REQ_MEM;
      end
    end
  end

  assign alu_ready = (grant == REQ_ALU);
  assign mem_ready = (grant == REQ_MEM);

  wb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (alu_ready || !alu_valid),
    .hold   (hold),
    .inc    (alu_valid && !alu_ready),
    .at_max (starve_at_max)
  );

  // Write-port next state: a grant loads the strobe; otherwise strobes drop and C/PW keep their value.
  always_comb begin
    c_d    = c_q;
    pw_d   = pw_q;
    rfld_d = 1'b0;
    pcld_d = 1'b0;
    case (grant)
      REQ_ALU: begin
        c_d    = alu_dest;
        pw_d   = alu_data;
        rfld_d = 1'b1;
        pcld_d = (alu_dest == AW'(REG_PC));
      end
      REQ_MEM: begin
        c_d    = mem_dest;
        pw_d   = mem_data;
        rfld_d = 1'b1;
        pcld_d = (mem_dest == AW'(REG_PC));
      end
      default: begin
      end
    endcase
  end

  // Write-port register; reset drops any pending strobe immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      c_q    <= '0;
      pw_q   <= '0;
      rfld_q <= 1'b0;
      pcld_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      pw_q   <= pw_d;
      rfld_q <= rfld_d;
      pcld_q <= pcld_d;
    end
  end

  assign C         = c_q;
  assign PW        = pw_q;
  assign RFLd      = rfld_q;
  assign PCLd      = pcld_q;
  assign pend_mask = rfld_q ? rf_onehot(RF_AW'(c_q)) : 16'h0000;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, scoreboard of expected writes.
// Latency: expected writes are tagged with the cycle they must appear on the write port.
// Backpressure: requesters hold their request until the arbiter accepts it.
module tb_rf_wb_arbiter;

  localparam int SMAX = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_dest = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        hold = 1'b0;
  logic [3:0]  C;
  logic [31:0] PW;
  logic        RFLd;
  logic        PCLd;
  logic [15:0] pend_mask;

  rf_wb_arbiter #(.DW(32), .AW(4), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .hold(hold), .C(C), .PW(PW), .RFLd(RFLd), .PCLd(PCLd), .pend_mask(pend_mask)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  c;
    logic [31:0] pw;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: how many consecutive cycles the pending ALU request has been refused.
  int alu_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the write port must show exactly the write due this cycle, or nothing.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("wr_rfld", RFLd, 1'b1);
        check("wr_c", C, e.c);
        check("wr_pw", PW, e.pw);
        check("wr_pcld", PCLd, e.c == 4'd15);
        check("wr_pend", pend_mask, 16'h1 << e.c);
      end else begin
        check("idle_rfld", RFLd, 1'b0);
        check("idle_pend", pend_mask, 16'h0);
      end
    end
  end

  // Apply one cycle of requests (called at a negedge), check readys against the model, log expected write.
  task automatic drive_cycle(input logic av, input logic [3:0] ad, input logic [31:0] adt,
                             input logic mv, input logic [3:0] md, input logic [31:0] mdt,
                             input logic h, output int g, output logic got_alu, output logic got_mem);
    exp_t e;
    alu_valid = av; alu_dest = ad; alu_data = adt;
    mem_valid = mv; mem_dest = md; mem_data = mdt;
    hold = h;
    #1;
    got_alu = alu_ready;
    got_mem = mem_ready;
    if (h)            g = 0;
    else if (av && mv) g = (alu_wait >= SMAX) ? 1 : 2;
    else if (av)      g = 1;
    else if (mv)      g = 2;
    else              g = 0;
    check("alu_ready", got_alu, g == 1);
    check("mem_ready", got_mem, g == 2);
    if (g == 1) begin
      e.due = cyc + 1; e.c = ad; e.pw = adt; exp_q.push_back(e);
    end else if (g == 2) begin
      e.due = cyc + 1; e.c = md; e.pw = mdt; exp_q.push_back(e);
    end
    if (!av || g == 1) alu_wait = 0;
    else if (!h)       alu_wait = (alu_wait + 1 > SMAX) ? SMAX : alu_wait + 1;
    @(negedge CLK);
  endtask

  initial begin
    int   g;
    logic ga, gm;
    int   pat[8];
    logic [31:0] atag;
    logic        a_has, m_has;
    logic [3:0]  a_d, m_d;
    logic [31:0] a_x, m_x;

    // Reset with both requesters active: nothing may be accepted or written.
    alu_valid = 1'b1; mem_valid = 1'b1; alu_dest = 4'd1; mem_dest = 4'd2;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_rfld", RFLd, 1'b0);
    check("rst_c", C, 4'd0);
    check("rst_pw", PW, 32'd0);
    check("rst_pend", pend_mask, 16'h0);
    @(negedge CLK);
    RST = 1'b1;
    alu_wait = 0;
    drive_cycle(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0, g, ga, gm);
    check("rst_first_mem", gm, 1'b1);
    drive_cycle(1'b1, 4'd1, 32'h11, 1'b0, 4'd0, 32'h0, 1'b0, g, ga, gm);
    drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, g, ga, gm);

    // Single ALU write.
    drive_cycle(1'b1, 4'd3, 32'd90, 1'b0, 4'd0, 32'h0, 1'b0, g, ga, gm);
    check("alu_single_ready", ga, 1'b1);
    check("alu_single_rfld", RFLd, 1'b1);
    check("alu_single_c", C, 4'd3);
    check("alu_single_pw", PW, 32'd90);
    check("alu_single_pcld", PCLd, 1'b0);
    check("alu_single_pend", pend_mask, 16'h0008);
    drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, g, ga, gm);
    check("alu_single_drop", RFLd, 1'b0);

    // Starvation guard under continuous contention.
    pat = '{2, 2, 2, 1, 2, 2, 2, 1};
    atag = 32'hA000;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 4'd4, atag, 1'b1, 4'd5, 32'hB000 + i, 1'b0, g, ga, gm);
      check("starve_alu", ga, pat[i] == 1);
      check("starve_mem", gm, pat[i] == 2);
      if (ga) atag = atag + 1;
    end
    drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, g, ga, gm);

    // Load to the PC register.
    drive_cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'd35, 1'b0, g, ga, gm);
    check("r15_rfld", RFLd, 1'b1);
    check("r15_pcld", PCLd, 1'b1);
    check("r15_c", C, 4'd15);
    check("r15_pw", PW, 32'd35);
    check("r15_pend", pend_mask, 16'h8000);
    drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, g, ga, gm);

    // Hold freezes grants and the starvation count: two losses, two held, then one more loss, then ALU.
    pat = '{2, 2, 0, 0, 2, 1, 2, 2};
    atag = 32'hC000;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 4'd6, atag, 1'b1, 4'd7, 32'hD000 + i, (i == 2 || i == 3), g, ga, gm);
      check("hold_alu", ga, pat[i] == 1);
      check("hold_mem", gm, pat[i] == 2);
      if (ga) atag = atag + 1;
    end
    drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, g, ga, gm);

    // Reset while a write strobe is being presented.
    drive_cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd10, 32'd16, 1'b0, g, ga, gm);
    check("mrst_pre_rfld", RFLd, 1'b1);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check("mrst_rfld", RFLd, 1'b0);
    check("mrst_c", C, 4'd0);
    check("mrst_pw", PW, 32'd0);
    check("mrst_pend", pend_mask, 16'h0);
    exp_q.delete();
    alu_wait = 0;
    @(negedge CLK);
    RST = 1'b1;

    // Random traffic with held requests and occasional hold.
    a_has = 1'b0; m_has = 1'b0;
    a_d = '0; m_d = '0; a_x = '0; m_x = '0;
    for (int i = 0; i < 500; i++) begin
      if (!a_has && ($urandom_range(0, 2) != 0)) begin
        a_has = 1'b1; a_d = 4'($urandom_range(0, 15)); a_x = $urandom;
      end
      if (!m_has && ($urandom_range(0, 3) != 0)) begin
        m_has = 1'b1; m_d = 4'($urandom_range(0, 15)); m_x = $urandom;
      end
      drive_cycle(a_has, a_d, a_x, m_has, m_d, m_x, ($urandom_range(0, 6) == 0), g, ga, gm);
      if (ga) a_has = 1'b0;
      if (gm) m_has = 1'b0;
    end
    repeat (2) drive_cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, g, ga, gm);
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
